// File: rtl/spi_par_master.sv
// SPI master for a bus of parallel-mode slaves: sends one byte LSB-first, collects the 8-bit echo,
// checks the slave's done flag, and runs a 17-period flush after reset to return every slave to idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FLUSH | after reset: cs all high, 17 SCLK periods so every slave idles
// ST_IDLE  | sclk high, cs all high, accepts start
// ST_TX    | cs[sel] low, rises 1..8 advance mosi through the byte
// ST_RX    | rises 9..16 sample miso[sel] into the receive shifter
// ST_TRAIL | cs high again, one more period so fall 17 clears the slave
module spi_par_master #(
   parameter int NUM_SLAVES = 2,
   parameter int SEL_W      = 1,
   parameter int CLK_DIV    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            tx_data,
   input  logic [SEL_W-1:0]      sel,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            rx_data,
   output logic                  ack_err,
   output logic                  sclk,
   output logic                  mosi,
   output logic [NUM_SLAVES-1:0] cs,
   input  logic [NUM_SLAVES-1:0] miso,
   input  logic [NUM_SLAVES-1:0] slv_done
);

   localparam int                    DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]      DIV_LOAD     = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]      DIV_ONE      = DIV_W'(1);
   localparam logic [NUM_SLAVES-1:0] CS_IDLE      = '1;
   // rise_q holds the number of rises already seen, so these match rises 8, 16 and 17
   localparam logic [4:0]            LAST_TX_RISE = 5'd7;
   localparam logic [4:0]            LAST_RX_RISE = 5'd15;
   localparam logic [4:0]            LAST_RISE    = 5'd16;

   typedef enum logic [2:0] {
      ST_FLUSH,
      ST_IDLE,
      ST_TX,
      ST_RX,
      ST_TRAIL
   } state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    sclk_q, sclk_d;
   logic [4:0]              rise_q, rise_d;
   logic [NUM_SLAVES-1:0]   cs_q, cs_d;
   logic                    mosi_q, mosi_d;
   logic [7:0]              tx_sh_q, tx_sh_d;
   logic [7:0]              rx_sh_q, rx_sh_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic                    err_q, err_d;
   logic                    done_q, done_d;
   logic [7:0]              rx_data_q, rx_data_d;
   logic                    ack_err_q, ack_err_d;

   logic                    tick;
   logic                    rise_evt;
   logic                    miso_bit;
   logic                    slv_done_bit;
   logic                    sel_oor;

   assign sel_oor = (int'(sel) >= NUM_SLAVES);

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      sclk_d       = sclk_q;
      rise_d       = rise_q;
      cs_d         = cs_q;
      mosi_d       = mosi_q;
      tx_sh_d      = tx_sh_q;
      rx_sh_d      = rx_sh_q;
      sel_d        = sel_q;
      err_d        = err_q;
      done_d       = 1'b0;
      rx_data_d    = rx_data_q;
      ack_err_d    = ack_err_q;
      miso_bit     = 1'b0;
      slv_done_bit = 1'b0;
      rise_evt     = 1'b0;
      tick         = (div_q == '0);

      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q == SEL_W'(i)) begin
            miso_bit     = miso[i];
            slv_done_bit = slv_done[i];
         end
      end

      // the divider runs in every state except IDLE; sclk idles high so the first toggle is a fall
      if (state_q != ST_IDLE) begin
         if (tick) begin
            div_d    = DIV_LOAD;
            sclk_d   = ~sclk_q;
            rise_evt = ~sclk_q;
         end else begin
            div_d = div_q - DIV_ONE;
         end
         if (rise_evt) begin
            rise_d = rise_q + 5'd1;
         end
      end

      case (state_q)
         ST_FLUSH: begin
            if (rise_evt && (rise_q == LAST_RISE)) begin
               state_d = ST_IDLE;
               rise_d  = '0;
            end
         end
         ST_IDLE: begin
            div_d  = DIV_LOAD;
            sclk_d = 1'b1;
            rise_d = '0;
            mosi_d = 1'b0;
            cs_d   = CS_IDLE;
            if (start) begin
               if (sel_oor) begin
                  done_d    = 1'b1;
                  ack_err_d = 1'b1;
               end else begin
                  state_d = ST_TX;
                  sel_d   = sel;
                  tx_sh_d = tx_data;
                  mosi_d  = tx_data[0];
                  for (int i = 0; i < NUM_SLAVES; i++) begin
                     cs_d[i] = (sel != SEL_W'(i));
                  end
               end
            end
         end
         ST_TX: begin
            if (rise_evt) begin
               mosi_d  = tx_sh_q[1];
               tx_sh_d = {1'b0, tx_sh_q[7:1]};
               if (rise_q == LAST_TX_RISE) begin
                  state_d = ST_RX;
               end
            end
         end
         ST_RX: begin
            if (rise_evt) begin
               rx_sh_d = {miso_bit, rx_sh_q[7:1]};
               if (rise_q == LAST_RX_RISE) begin
                  state_d = ST_TRAIL;
                  cs_d    = CS_IDLE;
                  err_d   = ~slv_done_bit;
               end
            end
         end
         ST_TRAIL: begin
            if (rise_evt) begin
               state_d   = ST_IDLE;
               rise_d    = '0;
               done_d    = 1'b1;
               rx_data_d = rx_sh_q;
               ack_err_d = err_q;
            end
         end
         default: begin
            state_d = ST_FLUSH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FLUSH;
         div_q     <= DIV_LOAD;
         sclk_q    <= 1'b1;
         rise_q    <= '0;
         cs_q      <= CS_IDLE;
         mosi_q    <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         sel_q     <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         rx_data_q <= '0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         sclk_q    <= sclk_d;
         rise_q    <= rise_d;
         cs_q      <= cs_d;
         mosi_q    <= mosi_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         sel_q     <= sel_d;
         err_q     <= err_d;
         done_q    <= done_d;
         rx_data_q <= rx_data_d;
         ack_err_q <= ack_err_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign ack_err = ack_err_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs      = cs_q;

endmodule

// File: tb/tb_spi_par_master.sv
// Bench for spi_par_master: behavioural echo slaves on the bus, randomized transfers, and
// expectations taken from the transfer timing rules (latency, cs window, fall counts, echo).
module tb_spi_par_master;

   localparam int NS  = 2;
   localparam int SW  = 2;
   localparam int D   = 2;
   localparam int LAT = 34 * D + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    tx_data;
   logic [SW-1:0] sel;
   logic          busy;
   logic          done;
   logic [7:0]    rx_data;
   logic          ack_err;
   logic          sclk;
   logic          mosi;
   logic [NS-1:0] cs;
   logic [NS-1:0] s_miso;
   logic [NS-1:0] s_done;
   logic [NS-1:0] slv_done;
   logic          stuck;

   assign slv_done = stuck ? '0 : s_done;

   spi_par_master #(.NUM_SLAVES(NS), .SEL_W(SW), .CLK_DIV(D)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .sel(sel),
      .busy(busy), .done(done), .rx_data(rx_data), .ack_err(ack_err),
      .sclk(sclk), .mosi(mosi), .cs(cs), .miso(s_miso), .slv_done(slv_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // slave devices: they act on sclk falls only, have no reset, and echo the byte they received
   int         scnt[NS];
   logic [7:0] ssh[NS];
   logic [7:0] slv_rx[NS];
   bit         s_init = 1'b0;

   always @(negedge sclk) begin
      int k;
      if (!s_init) begin
         for (int i = 0; i < NS; i++) begin
            scnt[i]   = $urandom_range(0, 15);
            ssh[i]    = 8'($urandom);
            s_done[i] = 1'($urandom);
            s_miso[i] = 1'($urandom);
         end
         s_init = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
         if (scnt[i] == 0) begin
            if (!cs[i]) begin
               ssh[i][0] = mosi;
               scnt[i]   = 1;
            end else begin
               s_done[i] = 1'b0;
               s_miso[i] = 1'b0;
            end
         end else if (scnt[i] < 8) begin
            k = scnt[i];
            ssh[i][k[2:0]] = mosi;
            if (scnt[i] == 7) slv_rx[i] = ssh[i];
            scnt[i]++;
         end else begin
            k = scnt[i] - 8;
            s_miso[i] = ssh[i][k[2:0]];
            if (scnt[i] == 15) begin
               s_done[i] = 1'b1;
               scnt[i]   = 0;
            end else begin
               scnt[i]++;
            end
         end
      end
   end

   int   busy_cyc = 0;
   int   falls    = 0;
   int   done_cnt = 0;
   int   multi_cs = 0;
   int   cs_low[NS];
   logic sclk_prev = 1'b1;

   initial for (int i = 0; i < NS; i++) cs_low[i] = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cyc++;
      if (sclk_prev === 1'b1 && sclk === 1'b0) falls++;
      sclk_prev = sclk;
      if (done === 1'b1) done_cnt++;
      if ($countones(~cs) > 1) multi_cs++;
      for (int i = 0; i < NS; i++) if (cs[i] === 1'b0) cs_low[i]++;
   end

   int exp_done = 0;

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic do_xfer(input logic [7:0] d, input logic [SW-1:0] s, input logic exp_err,
                          input bit noise);
      int t0, f0, n;
      int c0[NS];
      wait_idle("xfer");
      chk("slv_done_clear", 32'(slv_done), 32'd0);
      for (int i = 0; i < NS; i++) c0[i] = cs_low[i];
      f0 = falls;
      start = 1'b1; tx_data = d; sel = s; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_rise", 32'(busy), 32'd1);
      n = 0;
      while (done !== 1'b1 && n < 150) begin
         @(posedge clk); #1;
         n++;
         if (done !== 1'b1 && noise) begin
            start   = ($urandom_range(0, 5) == 0);
            tx_data = 8'($urandom);
            sel     = SW'($urandom);
         end
      end
      start = 1'b0;
      exp_done++;
      chk("latency", 32'(cyc - t0), 32'(LAT));
      chk("busy_fall", 32'(busy), 32'd0);
      chk("rx_data", 32'(rx_data), 32'(d));
      chk("ack_err", 32'(ack_err), 32'(exp_err));
      chk("slave_got", 32'(slv_rx[s]), 32'(d));
      chk("falls", 32'(falls - f0), 32'd17);
      for (int i = 0; i < NS; i++)
         chk("cs_window", 32'(cs_low[i] - c0[i]), (i == int'(s)) ? 32'(32 * D) : 32'd0);
   endtask

   task automatic do_oor(input logic [SW-1:0] s);
      int f0;
      logic [7:0] rx0;
      wait_idle("oor");
      f0  = falls;
      rx0 = rx_data;
      start = 1'b1; tx_data = 8'($urandom); sel = s;
      @(posedge clk); #1;
      start = 1'b0;
      exp_done++;
      chk("oor_done", 32'(done), 32'd1);
      chk("oor_ack_err", 32'(ack_err), 32'd1);
      chk("oor_busy", 32'(busy), 32'd0);
      chk("oor_rx_hold", 32'(rx_data), 32'(rx0));
      chk("oor_cs", 32'(cs), 32'({NS{1'b1}}));
      @(posedge clk); #1;
      chk("oor_done_pulse", 32'(done), 32'd0);
      chk("oor_no_sclk", 32'(falls - f0), 32'd0);
   endtask

   task automatic check_flush(input string tag);
      int b0, f0, c0;
      b0 = busy_cyc; f0 = falls; c0 = cs_low[0] + cs_low[1];
      rst = 1'b0;
      wait_idle(tag);
      chk({tag, "_busy_len"}, 32'(busy_cyc - b0), 32'(34 * D));
      chk({tag, "_falls"}, 32'(falls - f0), 32'd17);
      chk({tag, "_cs_high"}, 32'(cs_low[0] + cs_low[1] - c0), 32'd0);
      chk({tag, "_slv_done"}, 32'(slv_done), 32'd0);
   endtask

   initial begin
      int r, n, dc;
      logic prev;
      logic [7:0] d;
      rst = 1'b1; start = 1'b0; tx_data = '0; sel = '0; stuck = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sclk", 32'(sclk), 32'd1);
      chk("rst_cs", 32'(cs), 32'({NS{1'b1}}));
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_ack_err", 32'(ack_err), 32'd0);
      check_flush("flush");

      do_xfer(8'hA5, 2'd0, 1'b0, 1'b0);
      do_xfer(8'h3C, 2'd1, 1'b0, 1'b0);
      do_xfer(8'hFF, 2'd0, 1'b0, 1'b0);
      do_oor(2'd3);
      do_xfer(8'h5A, 2'd1, 1'b0, 1'b1);
      do_oor(2'd2);

      // reset at rise 5 of a transfer
      wait_idle("abort");
      start = 1'b1; tx_data = 8'hC3; sel = SW'($urandom_range(0, NS - 1));
      @(posedge clk); #1;
      start = 1'b0;
      r = 0; n = 0; prev = sclk;
      while (r < 5 && n < 100) begin
         @(posedge clk); #1;
         if (!prev && sclk) r++;
         prev = sclk;
         n++;
      end
      chk("rise5_seen", 32'(r), 32'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_cs", 32'(cs), 32'({NS{1'b1}}));
      chk("abort_sclk", 32'(sclk), 32'd1);
      chk("abort_mosi", 32'(mosi), 32'd0);
      chk("abort_busy", 32'(busy), 32'd1);
      dc = done_cnt;
      check_flush("reflush");
      chk("abort_no_done", 32'(done_cnt), 32'(dc));
      do_xfer(8'h81, SW'($urandom_range(0, NS - 1)), 1'b0, 1'b0);

      stuck = 1'b1;
      do_xfer(8'($urandom), SW'($urandom_range(0, NS - 1)), 1'b1, 1'b0);
      stuck = 1'b0;

      for (int t = 0; t < 6; t++) begin
         d = 8'($urandom);
         do_xfer(d, SW'($urandom_range(0, NS - 1)), 1'b0, ($urandom_range(0, 1) == 1));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("one_cs_low", 32'(multi_cs), 32'd0);
      chk("done_count", 32'(done_cnt), 32'(exp_done));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
